// File: rtl/multiword_add_sequencer.sv
// Wide adder sequencer: adds WORDS*WIDTH-bit operands with one WIDTH-bit prefix
// adder, one slice per clock, LSB slice first, carry chained between slices.
// Latency WORDS cycles accept-to-result; result held in DONE until out_ready.
// Ports: clk/rst_n; in_valid/in_ready + A/B/Cin operands; out_valid/out_ready
// + S/Cout registered result; busy high while an operation is in flight.

// Carry_lookahead_adder: WIDTH-bit combinational prefix adder. Bits are grouped
// GROUP at a time; group generate/propagate go through a radix-VALENCY
// Kogge-Stone style prefix tree, carries then ripple inside each group.
// Ports: A/B [WIDTH:1] operands (bit 1 = LSB), Cin carry in, S sum, Cout carry out.
module Carry_lookahead_adder #(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 2,
  parameter int GROUP   = 2
) (
  input  logic [WIDTH:1] A,
  input  logic [WIDTH:1] B,
  input  logic           Cin,
  output logic [WIDTH:1] S,
  output logic           Cout
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  // Number of prefix levels needed for the span to cover all groups.
  function automatic int prefix_levels();
    int span;
    int lv;
    span = 1;
    lv   = 0;
    while (span < NG) begin
      span = span * VALENCY;
      lv   = lv + 1;
    end
    return lv;
  endfunction

  localparam int LV = prefix_levels();

  logic [WIDTH-1:0] g, p, s;
  logic [NG-1:0]    gg, gp, ng, np;
  logic             c;

  always_comb begin : prefix_net
    int span;
    g    = A & B;
    p    = A ^ B;
    gg   = '0;
    gp   = '0;
    ng   = '0;
    np   = '0;
    s    = '0;
    c    = 1'b0;
    span = 1;

    // Per-group generate/propagate; a short top group is handled by the bound.
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int b = 0; b < GROUP; b++) begin
        if (j * GROUP + b < WIDTH) begin
          gg[j] = g[j*GROUP+b] | (p[j*GROUP+b] & gg[j]);
          gp[j] = gp[j] & p[j*GROUP+b];
        end
      end
    end

    // Each level folds up to VALENCY-1 lower spans into every node, so after
    // the last level gg/gp[j] cover groups 0..j.
    for (int l = 0; l < LV; l++) begin
      ng = gg;
      np = gp;
      for (int j = 0; j < NG; j++) begin
        for (int k = 1; k < VALENCY; k++) begin
          if (j - k * span >= 0) begin
            ng[j] = ng[j] | (np[j] & gg[j-k*span]);
            np[j] = np[j] & gp[j-k*span];
          end
        end
      end
      gg   = ng;
      gp   = np;
      span = span * VALENCY;
    end

    // Carry into each group from the prefix, then ripple through its bits.
    for (int j = 0; j < NG; j++) begin
      if (j == 0) begin
        c = Cin;
      end else begin
        c = gg[j-1] | (gp[j-1] & Cin);
      end
      for (int b = 0; b < GROUP; b++) begin
        if (j * GROUP + b < WIDTH) begin
          s[j*GROUP+b] = p[j*GROUP+b] ^ c;
          c            = g[j*GROUP+b] | (p[j*GROUP+b] & c);
        end
      end
    end
  end

  assign S    = s;
  assign Cout = gg[NG-1] | (gp[NG-1] & Cin);

endmodule

module multiword_add_sequencer #(
  parameter int WIDTH   = 16,
  parameter int VALENCY = 2,
  parameter int GROUP   = 2,
  parameter int WORDS   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS:1]   A,
  input  logic [WIDTH*WORDS:1]   B,
  input  logic                   Cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS:1]   S,
  output logic                   Cout,
  output logic                   busy
);

  localparam int            N    = WIDTH * WORDS;
  localparam int            IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N:1]     a_q, b_q, s_q;
  logic           carry_q, cout_q;
  logic [IW-1:0]  idx;
  logic [WIDTH:1] slice_a, slice_b, slice_s;
  logic           slice_cout;
  logic           last_slice;

  // The adder only ever sees the latched operands, never the input pins.
  assign slice_a    = a_q[idx*WIDTH+1 +: WIDTH];
  assign slice_b    = b_q[idx*WIDTH+1 +: WIDTH];
  assign last_slice = (idx == LAST);

  Carry_lookahead_adder #(
    .WIDTH   (WIDTH),
    .VALENCY (VALENCY),
    .GROUP   (GROUP)
  ) u_cla (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            idx     <= '0;
          end
        end
        RUN: begin
          s_q[idx*WIDTH+1 +: WIDTH] <= slice_s;
          carry_q                   <= slice_cout;
          if (last_slice) begin
            cout_q <= slice_cout;
            // Park idx at 0 so the slice select never leaves the operand range.
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [64:1] a, b, s;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
  logic [16:1] a1, b1, s1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.WIDTH(16), .VALENCY(2), .GROUP(2), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Cout(cout), .busy(busy)
  );

  multiword_add_sequencer #(.WIDTH(16), .VALENCY(2), .GROUP(2), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .Cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .S(s1), .Cout(cout1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge and confirm the sequencer took them.
  task automatic start_op(input string tag, input logic [64:1] av, input logic [64:1] bv,
                          input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_acc_busy"}, 65'(busy), 65'(1));
    check({tag, "_acc_rdy"}, 65'(in_ready), 65'(0));
  endtask

  // Count cycles from acceptance to out_valid, then check the result.
  task automatic wait_result(input string tag, input logic [64:1] es, input logic ec);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 65'(n), 65'(4));
    check({tag, "_s"}, {1'b0, s}, {1'b0, es});
    check({tag, "_cout"}, 65'(cout), 65'(ec));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_hs_rdy"}, 65'(in_ready), 65'(1));
    check({tag, "_hs_ov"}, 65'(out_valid), 65'(0));
    out_ready = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [16:1] av, input logic [16:1] bv,
                      input logic cv, input logic [16:1] es, input logic ec);
    int n;
    a1 = av; b1 = bv; cin1 = cv; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 65'(n), 65'(1));
    check({tag, "_s"}, 65'(s1), 65'(es));
    check({tag, "_cout"}, 65'(cout1), 65'(ec));
    out_ready1 = 1'b1;
    tick();
    check({tag, "_hs_rdy"}, 65'(in_ready1), 65'(1));
    out_ready1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #12;
    check("rst_in_ready", 65'(in_ready), 65'(1));
    check("rst_out_valid", 65'(out_valid), 65'(0));
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_s", {1'b0, s}, 65'(0));
    check("rst_cout", 65'(cout), 65'(0));
    rst_n = 1'b1;
    tick();

    // 1: carry ripples through every slice
    start_op("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_result("t1", 64'd0, 1'b1);
    handshake("t1");

    // 2: back-to-back with out_ready held high; no accept during the handshake
    out_ready = 1'b1;
    start_op("t2a", 64'd55000, 64'd7000, 1'b1);
    wait_result("t2a", 64'd62001, 1'b0);
    a = 64'd999; b = 64'd0; cin = 1'b1; in_valid = 1'b1;
    tick();
    check("t2_noacc_rdy", 65'(in_ready), 65'(1));
    check("t2_noacc_busy", 65'(busy), 65'(0));
    tick();
    in_valid = 1'b0;
    check("t2b_acc_busy", 65'(busy), 65'(1));
    wait_result("t2b", 64'd1000, 1'b0);
    tick();
    check("t2b_hs_rdy", 65'(in_ready), 65'(1));
    check("t2b_hs_ov", 65'(out_valid), 65'(0));
    out_ready = 1'b0;

    // 3: top-bit carry out, and per-slice carries into the middle slices
    start_op("t3a", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_result("t3a", 64'd0, 1'b1);
    handshake("t3a");
    start_op("t3b", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);
    wait_result("t3b", 64'h0001_0000_0001_0000, 1'b0);
    handshake("t3b");

    // 4: backpressure while new operands are offered
    start_op("t4", 64'd1234, 64'd4321, 1'b0);
    wait_result("t4", 64'd5555, 1'b0);
    a = 64'd10; b = 64'd20; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_bp_ov", 65'(out_valid), 65'(1));
      check("t4_bp_rdy", 65'(in_ready), 65'(0));
      check("t4_bp_s", {1'b0, s}, 65'(5555));
      check("t4_bp_cout", 65'(cout), 65'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_idle_rdy", 65'(in_ready), 65'(1));
    check("t4_idle_ov", 65'(out_valid), 65'(0));
    tick();
    in_valid = 1'b0;
    check("t4n_acc_busy", 65'(busy), 65'(1));
    wait_result("t4n", 64'd30, 1'b0);
    handshake("t4n");

    // 5: pins change right after acceptance; latched values must be used
    start_op("t5", 64'd100, 64'd200, 1'b0);
    a = 64'd5; b = 64'd7; cin = 1'b1;
    wait_result("t5", 64'd300, 1'b0);
    handshake("t5");

    // 6: reset two cycles into RUN
    start_op("t6", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    tick();
    tick();
    check("t6_pre_busy", 65'(busy), 65'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_s", {1'b0, s}, 65'(0));
    check("t6_rst_cout", 65'(cout), 65'(0));
    check("t6_rst_ov", 65'(out_valid), 65'(0));
    check("t6_rst_busy", 65'(busy), 65'(0));
    check("t6_rst_rdy", 65'(in_ready), 65'(1));
    #2;
    rst_n = 1'b1;
    tick();
    start_op("t6r", 64'd999, 64'd1, 1'b0);
    wait_result("t6r", 64'd1000, 1'b0);
    handshake("t6r");

    // WORDS=1 instance: single-cycle RUN, carry out, reset mid-RUN
    run1("w1a", 16'hFFFF, 16'd1, 1'b0, 16'd0, 1'b1);
    run1("w1b", 16'd999, 16'd1, 1'b0, 16'd1000, 1'b0);
    a1 = 16'hFFFF; b1 = 16'd1; cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1_run_busy", 65'(busy1), 65'(1));
    rst_n = 1'b0;
    #1;
    check("w1_rst_s", 65'(s1), 65'(0));
    check("w1_rst_ov", 65'(out_valid1), 65'(0));
    check("w1_rst_busy", 65'(busy1), 65'(0));
    check("w1_rst_rdy", 65'(in_ready1), 65'(1));
    #2;
    rst_n = 1'b1;
    tick();
    run1("w1c", 16'd999, 16'd1, 1'b0, 16'd1000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
